n_way_arb_mux: RTL and testbench
================================

# n_way_arb_mux

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a selectable grant mode: direct select or round-robin arbitration. Successor to the fixed 8-way 16-bit combinational mux. Funnels several producer streams (ALU results, memory read data, I/O words) into one registered output stream for the datapath. One output register stage: one word per cycle sustained, one cycle input-to-output latency.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- CHANNELS, 8, number of input channels (≥2, any integer; not restricted to powers of two)
- SELW, derived localparam = max(1, clog2(CHANNELS)), width of select/channel-ID fields; not overridable
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion synchronous to clk
- in_data  input  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i presents a word
- in_ready  output  CHANNELS  channel i word accepted this cycle
- mode  input  1  0 = direct select via sel, 1 = round-robin
- sel  input  SELW  channel index used in mode 0
- out_data  output  WIDTH  registered output word
- out_chan  output  SELW  source channel of out_data
- out_valid  output  1  out_data/out_chan hold a word
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- State: output register (out_data, out_chan, out_valid) and round-robin pointer ptr (SELW bits, range 0..CHANNELS-1).
- load_en = !out_valid || out_ready. Register loads only when load_en is high.
- Grant, mode 0: gnt = sel, gnt_valid = (sel < CHANNELS) && in_valid[sel]. sel ≥ CHANNELS gives no grant, no error.
- Grant, mode 1: gnt = first index i with in_valid[i] = 1, searching ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1; gnt_valid = |in_valid.
- in_ready[i] = load_en && gnt_valid && (gnt == i). At most one bit of in_ready is high per cycle. in_ready depends combinationally on in_valid, mode, sel, out_ready and state. Producers must not make in_valid depend on in_ready.
- Transfer in: in_valid[gnt] && in_ready[gnt]. Next edge: out_data ← channel gnt word, out_chan ← gnt, out_valid ← 1.
- Transfer out: out_valid && out_ready. If no transfer in occurs in the same cycle, out_valid ← 0, and out_data/out_chan hold their last values.
- Simultaneous out and in transfer: the register is replaced with the new word, out_valid stays 1, no bubble.
- While out_valid && !out_ready, out_data/out_chan are stable and all in_ready are 0.
- ptr updates only on a transfer in while mode = 1: ptr ← (gnt == CHANNELS-1) ? 0 : gnt+1. Mode-0 transfers do not move ptr.
- A mode or sel change affects only the next grant. A held output word is never altered.
- Non-granted channels keep their words; the block never drops or duplicates an accepted word.

## Timing
- Reset values (asynchronous, on rst_n low): out_valid = 0, out_data = 0, out_chan = 0, ptr = 0. in_ready is low during reset.
- Reset mid-operation: a held, undelivered word is discarded and ptr returns to 0.
- Latency: word accepted at edge k is visible on out_data with out_valid = 1 after edge k, and consumable in cycle k+1.
- Throughput: one word per cycle while out_ready = 1 and any eligible input is valid.
- Round-robin fairness: with all CHANNELS continuously valid and out_ready = 1, each channel is granted exactly once per CHANNELS consecutive transfers.

## Test plan
- Reset: drive rst_n low mid-cycle with out_valid = 1 -> out_valid, out_data, out_chan go to 0 immediately; after release, ptr = 0 (first RR grant with all valid is channel 0).
- Mode 0, default params: in_valid = 8'hFF, channel i data = 16'h1000+i, sel steps 0..7, out_ready = 1 -> outputs 16'h1000..16'h1007 with out_chan 0..7, one per cycle, 1-cycle latency; sel = 3 with in_valid[3] = 0 -> no in_ready, out_valid drops.
- Round-robin: in_valid = 8'hFF held, out_ready = 1 -> out_chan sequence 0,1,…,7,0; in_valid = 8'b0010_0100 from ptr = 0 -> grants 2,5,2,5.
- Backpressure: out_ready = 0 for 4 cycles with word 16'hBEEF held -> out_data stable, in_ready = 0; then out_ready = 1 -> 16'hBEEF consumed and next word loaded in the same cycle with no bubble.
- Parametrisation: CHANNELS = 5, WIDTH = 32, mode 0, sel = 6 -> no grant; mode 1 with all valid -> out_chan wraps 4 → 0.
- Mode switch with a held word: hold out_valid, toggle mode 1 → 0 -> held word unchanged; next grant follows sel, and ptr is unchanged by mode-0 transfers.

Source files
------------

// File: rtl/n_way_arb_mux_if.sv
// Bundle of the N-channel producer handshakes and the single registered output stream.
// slave is the arbiter side; master is the producer/consumer environment side.
interface n_way_arb_mux_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8
);
   localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SELW-1:0]           sel;
   logic [WIDTH-1:0]          out_data;
   logic [SELW-1:0]           out_chan;
   logic                      out_valid;
   logic                      out_ready;

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/n_way_arb_mux.sv
// N-channel registered mux: direct select (mode 0) or round-robin (mode 1) grant,
// one output register stage sustaining one word per cycle.
module n_way_arb_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8
) (
   input logic            clk,
   input logic            rst_n,
   n_way_arb_mux_if.slave bus
);
   localparam int SELW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   // Channels padded to a power of two so any sel value indexes safely;
   // padding slots are never valid, which makes out-of-range sel a no-grant.
   localparam int SLOTS = 1 << SELW;

   logic [SLOTS-1:0] valid_ext;
   logic [WIDTH-1:0] data_arr [SLOTS];

   logic [WIDTH-1:0] out_data_reg;
   logic [SELW-1:0]  out_chan_reg;
   logic             out_valid_reg;
   logic [SELW-1:0]  ptr_reg;
   logic [SELW-1:0]  ptr_next;

   logic [SELW-1:0]  rr_gnt;
   logic             rr_found;
   logic [SELW-1:0]  gnt;
   logic             gnt_valid;
   logic             load_en;
   logic             take;

   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         if (gi < CHANNELS) begin : g_real
            assign valid_ext[gi] = bus.in_valid[gi];
            assign data_arr[gi]  = bus.in_data[gi*WIDTH +: WIDTH];
         end else begin : g_pad
            assign valid_ext[gi] = 1'b0;
            assign data_arr[gi]  = '0;
         end
      end
   endgenerate

   // Circular search starting at ptr; first valid channel wins.
   always_comb begin
      int idx;
      rr_gnt   = '0;
      rr_found = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = int'(ptr_reg) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!rr_found && valid_ext[SELW'(idx)]) begin
            rr_found = 1'b1;
            rr_gnt   = SELW'(idx);
         end
      end
   end

   always_comb begin
      gnt       = bus.mode ? rr_gnt : bus.sel;
      gnt_valid = bus.mode ? rr_found : valid_ext[bus.sel];
      ptr_next  = (gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + SELW'(1);
   end

   assign load_en = !out_valid_reg || bus.out_ready;
   // Gated by rst_n so no producer sees an accept while reset is asserted.
   assign take    = rst_n && load_en && gnt_valid;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
         assign bus.in_ready[gi] = take && (gnt == SELW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_chan_reg  <= '0;
         out_valid_reg <= 1'b0;
         ptr_reg       <= '0;
      end else begin
         if (take) begin
            out_data_reg  <= data_arr[gnt];
            out_chan_reg  <= gnt;
            out_valid_reg <= 1'b1;
            if (bus.mode) ptr_reg <= ptr_next;
         end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.out_data  = out_data_reg;
   assign bus.out_chan  = out_chan_reg;
   assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_n_way_arb_mux.sv
// Directed bench for n_way_arb_mux: default 8x16 instance plus a 5x32 instance
// for non-power-of-two channel counts.
module tb_n_way_arb_mux;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   n_way_arb_mux_if #(.WIDTH(16), .CHANNELS(8)) bus_a ();
   n_way_arb_mux_if #(.WIDTH(32), .CHANNELS(5)) bus_b ();

   n_way_arb_mux #(.WIDTH(16), .CHANNELS(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   n_way_arb_mux #(.WIDTH(32), .CHANNELS(5)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_out(input string tag, input logic [15:0] d, input logic [2:0] c);
      chk({tag, "_valid"}, 64'(bus_a.out_valid), 64'd1);
      chk({tag, "_data"}, 64'(bus_a.out_data), 64'(d));
      chk({tag, "_chan"}, 64'(bus_a.out_chan), 64'(c));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus_a.in_valid  = '0;
      bus_a.out_ready = 1'b0;
      bus_a.mode      = 1'b0;
      bus_a.sel       = '0;
      for (int i = 0; i < 8; i++) bus_a.in_data[i*16 +: 16] = 16'h1000 + 16'(i);
      bus_b.in_valid  = '0;
      bus_b.out_ready = 1'b0;
      bus_b.mode      = 1'b0;
      bus_b.sel       = '0;
      for (int i = 0; i < 5; i++) bus_b.in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);

      // Reset state
      tick();
      tick();
      chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
      chk("rst_data", 64'(bus_a.out_data), 64'd0);
      chk("rst_chan", 64'(bus_a.out_chan), 64'd0);
      bus_a.in_valid = 8'hFF;
      #1;
      chk("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
      rst_n = 1'b1;
      bus_a.out_ready = 1'b1;

      // Mode 0: sel steps 0..7
      for (int s = 0; s < 8; s++) begin
         bus_a.sel = 3'(s);
         #1;
         chk($sformatf("m0_ready%0d", s), 64'(bus_a.in_ready), 64'(8'h01 << s));
         tick();
         chk_a_out($sformatf("m0_out%0d", s), 16'h1000 + 16'(s), 3'(s));
      end
      bus_a.sel = 3'd3;
      bus_a.in_valid = 8'hF7;
      #1;
      chk("m0_noval_ready", 64'(bus_a.in_ready), 64'd0);
      tick();
      chk("m0_noval_valid", 64'(bus_a.out_valid), 64'd0);
      chk("m0_noval_data", 64'(bus_a.out_data), 64'h1007);
      chk("m0_noval_chan", 64'(bus_a.out_chan), 64'd7);

      // Round-robin, all valid from ptr 0
      bus_a.mode = 1'b1;
      bus_a.in_valid = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk_a_out($sformatf("rr_all%0d", k), 16'h1000 + 16'(k % 8), 3'(k % 8));
      end

      // Asynchronous reset mid-cycle with a held word
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus_a.out_valid), 64'd0);
      chk("arst_data", 64'(bus_a.out_data), 64'd0);
      chk("arst_chan", 64'(bus_a.out_chan), 64'd0);
      chk("arst_in_ready", 64'(bus_a.in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk_a_out("rr_post_rst", 16'h1000, 3'd0);

      // Sparse round-robin: channels 2 and 5
      bus_a.in_valid = 8'b0010_0100;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_a_out($sformatf("rr_sparse%0d", k), (k % 2 == 0) ? 16'h1002 : 16'h1005,
                   (k % 2 == 0) ? 3'd2 : 3'd5);
      end

      // Backpressure with 16'hBEEF held
      bus_a.mode = 1'b0;
      bus_a.sel = 3'd4;
      bus_a.in_valid = 8'hFF;
      bus_a.in_data[4*16 +: 16] = 16'hBEEF;
      tick();
      chk_a_out("bp_load", 16'hBEEF, 3'd4);
      bus_a.out_ready = 1'b0;
      bus_a.sel = 3'd6;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp_ready%0d", k), 64'(bus_a.in_ready), 64'd0);
         tick();
         chk_a_out($sformatf("bp_hold%0d", k), 16'hBEEF, 3'd4);
      end
      bus_a.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(bus_a.in_ready), 64'h40);
      tick();
      chk_a_out("bp_nobubble", 16'h1006, 3'd6);
      bus_a.in_data[4*16 +: 16] = 16'h1004;

      // Mode switch with a held word; ptr is 6 here and must survive mode-0 transfers
      bus_a.out_ready = 1'b0;
      bus_a.mode = 1'b1;
      tick();
      chk_a_out("ms_hold_m1", 16'h1006, 3'd6);
      bus_a.mode = 1'b0;
      bus_a.sel = 3'd1;
      tick();
      chk_a_out("ms_hold_m0", 16'h1006, 3'd6);
      chk("ms_hold_ready", 64'(bus_a.in_ready), 64'd0);
      bus_a.out_ready = 1'b1;
      #1;
      chk("ms_sel_ready", 64'(bus_a.in_ready), 64'h02);
      tick();
      chk_a_out("ms_sel1", 16'h1001, 3'd1);
      bus_a.sel = 3'd2;
      tick();
      chk_a_out("ms_sel2", 16'h1002, 3'd2);
      bus_a.mode = 1'b1;
      tick();
      chk_a_out("ms_ptr6", 16'h1006, 3'd6);
      tick();
      chk_a_out("ms_ptr7", 16'h1007, 3'd7);
      tick();
      chk_a_out("ms_ptr0", 16'h1000, 3'd0);

      // CHANNELS = 5, WIDTH = 32
      bus_b.in_valid = 5'h1F;
      bus_b.out_ready = 1'b1;
      bus_b.mode = 1'b0;
      bus_b.sel = 3'd6;
      #1;
      chk("p5_sel6_ready", 64'(bus_b.in_ready), 64'd0);
      tick();
      chk("p5_sel6_valid", 64'(bus_b.out_valid), 64'd0);
      bus_b.sel = 3'd4;
      tick();
      chk("p5_sel4_valid", 64'(bus_b.out_valid), 64'd1);
      chk("p5_sel4_data", 64'(bus_b.out_data), 64'hA000_0004);
      bus_b.mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("p5_rr_chan%0d", k), 64'(bus_b.out_chan), 64'(k % 5));
         chk($sformatf("p5_rr_data%0d", k), 64'(bus_b.out_data), 64'(32'hA000_0000 + 32'(k % 5)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
